spatz_xif_offloader: RTL and testbench

SPATZ_XIF_OFFLOADER -- requirements
Module: spatz_xif_offloader

---
 rtl/core_v_xif_pkg.sv | 30 +++
 rtl/spatz_pkg.sv | 12 +
 rtl/lzc.sv | 27 ++
 rtl/spatz_xif_offloader.sv | 168 ++++++++++++++++
 tb/tb_spatz_xif_offloader.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_v_xif_pkg.sv
// X-interface (CORE-V-XIF) types shared between the core-side offloader and
// the coprocessor. Only the fields this slice exchanges are modelled.
package core_v_xif_pkg;

  localparam int unsigned X_ID_WIDTH  = 4;
  localparam int unsigned X_NUM_RS    = 2;
  localparam int unsigned X_RFR_WIDTH = 32;
  localparam int unsigned X_RFW_WIDTH = 32;

  typedef struct packed {
    logic [31:0]                          instr;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs;
    logic [X_NUM_RS-1:0]                  rs_valid;
    logic [X_ID_WIDTH-1:0]                id;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic loadstore;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
  } x_result_t;

endpackage

// File: rtl/spatz_pkg.sv
// Spatz-side bookkeeping types for the X-interface offloader.
package spatz_pkg;

  // Maximum number of issued, un-retired writeback instructions.
  localparam int unsigned NrOutstandingDefault = 4;

  // One in-flight instruction slot; the slot index doubles as the XIF id.
  typedef struct packed {
    logic [4:0] rd;
  } xif_slot_t;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE 0 counts trailing zeros (index of the
// lowest set bit), MODE 1 counts leading zeros. empty_o flags an all-zero input.
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  // Scan from the far end so the position nearest the counted edge wins.
  always_comb begin
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (MODE == 1'b0) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(i);
      end else begin
        if (in_i[WIDTH-1-i]) cnt_o = CNT_WIDTH'(i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/spatz_xif_offloader.sv
// Core-side X-interface offloader: buffers one offload request for issue,
// tracks outstanding instructions in id slots, scoreboards pending integer
// writebacks and funnels coprocessor results back to the register file.
module spatz_xif_offloader
  import spatz_pkg::*;
  import core_v_xif_pkg::*;
#(
  parameter int unsigned NrOutstanding = NrOutstandingDefault
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          off_req_valid_i,
  output logic          off_req_ready_o,
  input  logic [31:0]   off_req_instr_i,
  input  logic [31:0]   off_req_rs1_i,
  input  logic [31:0]   off_req_rs2_i,
  input  logic [1:0]    off_req_rs_valid_i,
  input  logic [4:0]    off_req_rd_i,
  output logic          off_illegal_o,
  output logic          x_issue_valid_o,
  input  logic          x_issue_ready_i,
  output x_issue_req_t  x_issue_req_o,
  input  x_issue_resp_t x_issue_resp_i,
  input  logic          x_result_valid_i,
  output logic          x_result_ready_o,
  input  x_result_t     x_result_i,
  output logic          wb_valid_o,
  input  logic          wb_ready_i,
  output logic [4:0]    wb_rd_o,
  output logic [31:0]   wb_data_o,
  output logic [31:0]   rd_busy_o,
  output logic          err_o
);

  // Slot index must fit in the XIF id field.
  localparam int unsigned IdW = $clog2(NrOutstanding);

  logic [NrOutstanding-1:0]            slot_valid_q;
  xif_slot_t [NrOutstanding-1:0]       slot_q;
  logic [31:0]                         rd_busy_q;
  logic                                stage_valid_q;
  x_issue_req_t                        stage_q;
  logic [4:0]                          stage_rd_q;
  logic                                wb_valid_q;
  logic [4:0]                          wb_rd_q;
  logic [31:0]                         wb_data_q;
  logic [IdW-1:0]                      wb_id_q;
  logic                                illegal_q, err_q, res_en_q;

  logic [IdW-1:0] free_id, stage_id, res_id;
  logic           no_free, rd_hazard, res_known, res_wb;
  logic           off_hs, issue_hs, issue_keep, res_hs, wb_hs;
  xif_slot_t      res_slot;

  // Lowest free slot; only registered slot state is seen, so a slot freed
  // this cycle becomes allocatable one cycle later.
  lzc #(.WIDTH(NrOutstanding), .MODE(1'b0)) i_free_lzc (
    .in_i    (~slot_valid_q),
    .cnt_o   (free_id),
    .empty_o (no_free)
  );

  assign stage_id   = stage_q.id[IdW-1:0];
  assign issue_hs   = stage_valid_q & x_issue_ready_i;
  assign issue_keep = x_issue_resp_i.accept & x_issue_resp_i.writeback;

  // A pending write to rd lives either in the busy bitmap or, before issue,
  // in the stage register; x0 is never tracked.
  assign rd_hazard = (off_req_rd_i != 5'd0) &
                     (rd_busy_q[off_req_rd_i] | (stage_valid_q & (stage_rd_q == off_req_rd_i)));
  assign off_req_ready_o = (~stage_valid_q | x_issue_ready_i) & ~no_free & ~rd_hazard;
  assign off_hs          = off_req_valid_i & off_req_ready_o;

  assign x_result_ready_o = res_en_q & (~wb_valid_q | wb_ready_i);
  assign res_hs    = x_result_valid_i & x_result_ready_o;
  assign wb_hs     = wb_valid_q & wb_ready_i;
  assign res_id    = x_result_i.id[IdW-1:0];
  assign res_known = (32'(x_result_i.id) < NrOutstanding) & slot_valid_q[res_id];
  assign res_slot  = slot_q[res_id];
  assign res_wb    = x_result_i.we & (res_slot.rd != 5'd0);

  // Issue stage: load on offload acceptance, drain on issue handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_valid_q <= 1'b0;
      stage_q       <= '0;
      stage_rd_q    <= '0;
    end else if (off_hs) begin
      stage_valid_q     <= 1'b1;
      stage_q.instr     <= off_req_instr_i;
      stage_q.rs        <= {off_req_rs2_i, off_req_rs1_i};
      stage_q.rs_valid  <= off_req_rs_valid_i;
      stage_q.id        <= X_ID_WIDTH'(free_id);
      stage_rd_q        <= off_req_rd_i;
    end else if (issue_hs) begin
      stage_valid_q <= 1'b0;
    end
  end

  // Slot and busy-bitmap bookkeeping; allocations only target free slots, so
  // they never collide with the releases below.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_valid_q <= '0;
      slot_q       <= '0;
      rd_busy_q    <= '0;
    end else begin
      if (issue_hs && !issue_keep) slot_valid_q[stage_id] <= 1'b0;
      if (res_hs && res_known && !res_wb) begin
        slot_valid_q[res_id]   <= 1'b0;
        rd_busy_q[res_slot.rd] <= 1'b0;
      end
      if (wb_hs) begin
        slot_valid_q[wb_id_q] <= 1'b0;
        rd_busy_q[wb_rd_q]    <= 1'b0;
      end
      if (issue_hs && issue_keep && (stage_rd_q != 5'd0)) rd_busy_q[stage_rd_q] <= 1'b1;
      if (off_hs) begin
        slot_valid_q[free_id] <= 1'b1;
        slot_q[free_id].rd    <= off_req_rd_i;
      end
    end
  end

  // Single-entry result buffer feeding the register-file write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_id_q    <= '0;
    end else if (res_hs && res_known && res_wb) begin
      wb_valid_q <= 1'b1;
      wb_rd_q    <= res_slot.rd;
      wb_data_q  <= x_result_i.data[31:0];
      wb_id_q    <= res_id;
    end else if (wb_hs) begin
      wb_valid_q <= 1'b0;
    end
  end

  // Status flags: illegal pulse, sticky unknown-id error, result enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
      res_en_q  <= 1'b0;
    end else begin
      illegal_q <= issue_hs & ~x_issue_resp_i.accept;
      err_q     <= err_q | (res_hs & ~res_known);
      res_en_q  <= 1'b1;
    end
  end

  assign x_issue_valid_o = stage_valid_q;
  assign x_issue_req_o   = stage_q;
  assign off_illegal_o   = illegal_q;
  assign err_o           = err_q;
  assign wb_valid_o      = wb_valid_q;
  assign wb_rd_o         = wb_rd_q;
  assign wb_data_o       = wb_data_q;
  assign rd_busy_o       = rd_busy_q;

  // Load/store class and the coprocessor's echoed rd are not needed here.
  logic unused_ok;
  assign unused_ok = ^{x_issue_resp_i.loadstore, x_result_i.rd};

endmodule

// File: tb/tb_spatz_xif_offloader.sv
// Directed bench for spatz_xif_offloader with a writeback scoreboard.
module tb_spatz_xif_offloader;
  import core_v_xif_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          off_req_valid_i = 1'b0;
  logic          off_req_ready_o;
  logic [31:0]   off_req_instr_i = '0;
  logic [31:0]   off_req_rs1_i = '0;
  logic [31:0]   off_req_rs2_i = '0;
  logic [1:0]    off_req_rs_valid_i = '0;
  logic [4:0]    off_req_rd_i = '0;
  logic          off_illegal_o;
  logic          x_issue_valid_o;
  logic          x_issue_ready_i = 1'b0;
  x_issue_req_t  x_issue_req_o;
  x_issue_resp_t x_issue_resp_i = '0;
  logic          x_result_valid_i = 1'b0;
  logic          x_result_ready_o;
  x_result_t     x_result_i = '0;
  logic          wb_valid_o;
  logic          wb_ready_i = 1'b1;
  logic [4:0]    wb_rd_o;
  logic [31:0]   wb_data_o;
  logic [31:0]   rd_busy_o;
  logic          err_o;

  spatz_xif_offloader #(.NrOutstanding(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .off_req_valid_i(off_req_valid_i), .off_req_ready_o(off_req_ready_o),
    .off_req_instr_i(off_req_instr_i), .off_req_rs1_i(off_req_rs1_i),
    .off_req_rs2_i(off_req_rs2_i), .off_req_rs_valid_i(off_req_rs_valid_i),
    .off_req_rd_i(off_req_rd_i), .off_illegal_o(off_illegal_o),
    .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
    .x_issue_req_o(x_issue_req_o), .x_issue_resp_i(x_issue_resp_i),
    .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
    .x_result_i(x_result_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .rd_busy_o(rd_busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;
  wb_exp_t wb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [4:0] rd);
    return 32'h0000_7057 | (32'(rd) << 7);
  endfunction

  // Writeback scoreboard: every register-file write must match the oldest
  // expectation pushed when its result was driven.
  always @(negedge clk_i) begin
    if (rst_ni && wb_valid_o && wb_ready_i) begin
      if (wb_q.size() == 0) chk("wb_unexpected", wb_valid_o, 1'b0);
      else begin
        wb_exp_t e;
        e = wb_q.pop_front();
        chk("wb_rd", wb_rd_o, e.rd);
        chk("wb_data", wb_data_o, e.data);
      end
    end
  end

  task automatic offload(input logic [4:0] rd, input int maxcyc, output bit ok);
    @(posedge clk_i); #1;
    off_req_valid_i    = 1'b1;
    off_req_rd_i       = rd;
    off_req_instr_i    = instr_of(rd);
    off_req_rs1_i      = 32'h1000 + 32'(rd);
    off_req_rs2_i      = 32'h2000 + 32'(rd);
    off_req_rs_valid_i = 2'b11;
    ok = 1'b0;
    for (int i = 0; i < maxcyc && !ok; i++) begin
      @(negedge clk_i);
      if (off_req_ready_o) ok = 1'b1;
    end
    if (ok) begin @(posedge clk_i); #1; end
    off_req_valid_i = 1'b0;
  endtask

  task automatic offload_ok(input logic [4:0] rd);
    bit ok;
    offload(rd, 10, ok);
    chk("offload_accept", ok, 1'b1);
  endtask

  task automatic issue(input bit acc, input bit wb, input int exp_id, input logic [4:0] rd);
    bit seen;
    logic [3:0] eid;
    seen = 1'b0;
    eid  = exp_id[3:0];
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_i);
      if (x_issue_valid_o) seen = 1'b1;
    end
    chk("issue_valid", x_issue_valid_o, 1'b1);
    if (seen) begin
      chk("issue_id", x_issue_req_o.id, eid);
      chk("issue_instr", x_issue_req_o.instr, instr_of(rd));
      chk("issue_rs1", x_issue_req_o.rs[0], 32'h1000 + 32'(rd));
      x_issue_resp_i  = '{accept: acc, writeback: wb, loadstore: 1'b0};
      x_issue_ready_i = 1'b1;
      @(posedge clk_i); #1;
      x_issue_ready_i = 1'b0;
      x_issue_resp_i  = '0;
    end
  endtask

  task automatic result(input int id, input logic [31:0] data, input bit we,
                        input bit exp_wb, input logic [4:0] exp_rd);
    bit ok;
    logic [3:0] rid;
    ok  = 1'b0;
    rid = id[3:0];
    @(posedge clk_i); #1;
    x_result_i       = '{id: rid, data: data, rd: exp_rd, we: we};
    x_result_valid_i = 1'b1;
    if (exp_wb) wb_q.push_back('{rd: exp_rd, data: data});
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk_i);
      if (x_result_ready_o) ok = 1'b1;
    end
    chk("result_accept", ok, 1'b1);
    if (ok) begin @(posedge clk_i); #1; end
    x_result_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_issue_valid", x_issue_valid_o, 1'b0);
    chk("rst_result_ready", x_result_ready_o, 1'b0);
    chk("rst_wb_valid", wb_valid_o, 1'b0);
    chk("rst_illegal", off_illegal_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_busy", rd_busy_o, 32'h0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("post_rst_result_ready", x_result_ready_o, 1'b1);
    chk("post_rst_off_ready", off_req_ready_o, 1'b1);

    // vsetvli to x5, writeback held off, hazards on x5
    @(posedge clk_i); #1 wb_ready_i = 1'b0;
    offload_ok(5'd5);
    offload(5'd5, 2, ok);
    chk("stage_hazard", ok, 1'b0);
    issue(1'b1, 1'b1, 0, 5'd5);
    @(negedge clk_i);
    chk("busy5_set", rd_busy_o[5], 1'b1);
    offload(5'd5, 3, ok);
    chk("rd_hazard", ok, 1'b0);
    result(0, 32'd16, 1'b1, 1'b1, 5'd5);
    @(negedge clk_i);
    chk("wb_valid_next", wb_valid_o, 1'b1);
    chk("busy5_held", rd_busy_o[5], 1'b1);
    repeat (2) @(negedge clk_i);
    chk("wb_valid_held", wb_valid_o, 1'b1);
    chk("busy5_still", rd_busy_o[5], 1'b1);
    @(posedge clk_i); #1 wb_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("busy5_clear", rd_busy_o, 32'h0);
    offload(5'd5, 3, ok);
    chk("rd5_after_wb", ok, 1'b1);
    issue(1'b1, 1'b0, 0, 5'd5);

    // Rejected instruction: one illegal pulse, slot 0 reused
    offload_ok(5'd6);
    issue(1'b0, 1'b1, 0, 5'd6);
    @(negedge clk_i);
    chk("illegal_pulse", off_illegal_o, 1'b1);
    @(negedge clk_i);
    chk("illegal_once", off_illegal_o, 1'b0);
    offload_ok(5'd6);
    issue(1'b1, 1'b0, 0, 5'd6);
    repeat (2) @(negedge clk_i);
    chk("no_busy_after_reject", rd_busy_o, 32'h0);

    // Fill all slots, fifth request stalls until a retirement
    for (int r = 1; r <= 4; r++) begin
      offload_ok(5'(r));
      issue(1'b1, 1'b1, r - 1, 5'(r));
    end
    @(negedge clk_i);
    chk("busy_full", rd_busy_o, 32'h0000_001E);
    offload(5'd8, 4, ok);
    chk("full_stall", ok, 1'b0);
    result(2, 32'h0000_00A2, 1'b1, 1'b1, 5'd3);
    repeat (3) @(negedge clk_i);
    offload_ok(5'd8);
    issue(1'b1, 1'b1, 2, 5'd8);
    result(0, 32'h0000_00A0, 1'b1, 1'b1, 5'd1);
    result(1, 32'h0000_00A1, 1'b1, 1'b1, 5'd2);
    result(3, 32'h0000_00A3, 1'b1, 1'b1, 5'd4);
    result(2, 32'h0000_00B2, 1'b1, 1'b1, 5'd8);
    repeat (3) @(negedge clk_i);
    chk("busy_drained", rd_busy_o, 32'h0);

    // Back-to-back results with the register file stalled
    @(posedge clk_i); #1 wb_ready_i = 1'b0;
    offload_ok(5'd10);
    issue(1'b1, 1'b1, 0, 5'd10);
    offload_ok(5'd11);
    issue(1'b1, 1'b1, 1, 5'd11);
    result(0, 32'h0000_0100, 1'b1, 1'b1, 5'd10);
    @(posedge clk_i); #1;
    x_result_i       = '{id: 4'd1, data: 32'h0000_0111, rd: 5'd11, we: 1'b1};
    x_result_valid_i = 1'b1;
    wb_q.push_back('{rd: 5'd11, data: 32'h0000_0111});
    @(negedge clk_i);
    chk("result_backpressure", x_result_ready_o, 1'b0);
    @(negedge clk_i);
    chk("result_backpressure2", x_result_ready_o, 1'b0);
    @(posedge clk_i); #1 wb_ready_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk_i);
      if (x_result_ready_o) ok = 1'b1;
    end
    chk("second_result_accept", ok, 1'b1);
    @(posedge clk_i); #1 x_result_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("no_result_lost", wb_q.size(), 0);
    chk("busy_after_b2b", rd_busy_o, 32'h0);

    // we=0 result retires silently; unknown id sets sticky error
    chk("err_clear", err_o, 1'b0);
    offload_ok(5'd12);
    issue(1'b1, 1'b1, 0, 5'd12);
    result(0, 32'h0000_0005, 1'b0, 1'b0, 5'd12);
    repeat (2) @(negedge clk_i);
    chk("we0_busy_clear", rd_busy_o, 32'h0);
    result(3, 32'h0000_DEAD, 1'b1, 1'b0, 5'd7);
    @(negedge clk_i);
    chk("err_set", err_o, 1'b1);
    repeat (3) @(negedge clk_i);
    chk("err_sticky", err_o, 1'b1);

    // Reset mid-flight drops the pending writeback
    offload_ok(5'd9);
    issue(1'b1, 1'b1, 0, 5'd9);
    @(posedge clk_i); #1 wb_ready_i = 1'b0;
    result(0, 32'h0000_0099, 1'b1, 1'b0, 5'd9);
    @(negedge clk_i);
    chk("pre_reset_wb_valid", wb_valid_o, 1'b1);
    @(posedge clk_i); #1 rst_ni = 1'b0;
    #1;
    chk("midrst_wb_valid", wb_valid_o, 1'b0);
    chk("midrst_busy", rd_busy_o, 32'h0);
    chk("midrst_err", err_o, 1'b0);
    @(posedge clk_i); #1;
    rst_ni     = 1'b1;
    wb_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("post_midrst_wb", wb_valid_o, 1'b0);
    offload(5'd9, 5, ok);
    chk("post_midrst_rd9", ok, 1'b1);
    issue(1'b1, 1'b0, 0, 5'd9);
    repeat (2) @(negedge clk_i);
    chk("final_queue_empty", wb_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
